// File: rtl/halt_detect.sv
// halt_detect
//
// Retire-side halt detector for the pipelined CPU. It sits between writeback
// and the simulation cycle counter. It does three things:
//   - shadows architectural register RET_REG from writeback traffic;
//   - counts retired instructions, saturating at all-ones;
//   - when a halt retires, waits DRAIN_CYCLES cycles with no store pending,
//     then raises a sticky isHalt together with a frozen ret_val.
//
// Parameters
//   RET_REG       register reported as ret_val (0 => ret_val stays 0)
//   DRAIN_CYCLES  non-pending cycles after the halt before isHalt, 1..15
//
// Ports
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   wb_valid       an instruction retires this cycle
//   wb_is_halt     retiring instruction is a halt (qualified by wb_valid)
//   wb_we          retiring instruction writes rd (qualified by wb_valid)
//   wb_rd          destination register
//   wb_data        writeback data
//   store_pending  memory stage holds an uncommitted store
//   isHalt         registered, sticky halt flag
//   ret_val        registered shadow of RET_REG
//   retired        registered saturating retired-instruction count
module halt_detect #(
  parameter int RET_REG      = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic        wb_is_halt,
  input  logic        wb_we,
  input  logic [2:0]  wb_rd,
  input  logic [15:0] wb_data,
  input  logic        store_pending,
  output logic        isHalt,
  output logic [15:0] ret_val,
  output logic [31:0] retired
);

  localparam logic [2:0] RET_IDX    = RET_REG[2:0];
  localparam bit         RET_EN     = (RET_REG != 0);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] drain_cnt;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Single registered FSM; every output is a flop, so no input reaches an
  // output combinationally and ret_val is frozen from DRAIN entry onward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
      isHalt    <= 1'b0;
      ret_val   <= 16'd0;
      retired   <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (wb_valid) begin
            retired <= sat_inc(retired);
            if (wb_is_halt) begin
              // The halt's own register write is deliberately dropped.
              state     <= DRAIN;
              drain_cnt <= 4'd0;
            end else if (wb_we && RET_EN && (wb_rd == RET_IDX)) begin
              ret_val <= wb_data;
            end
          end
        end
        DRAIN: begin
          // A pending store stalls the count; there is no timeout.
          if (!store_pending) begin
            if (drain_cnt == DRAIN_LAST) begin
              state  <= HALTED;
              isHalt <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 4'd1;
            end
          end
        end
        HALTED: begin
          // Everything frozen until reset.
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/halt_detect.md
# halt_detect

Retire-side halt detector for the pipelined CPU. It sits between the writeback stage and the simulation cycle counter. It shadows the return-value register from writeback traffic and detects retirement of a halt instruction. After a fixed drain window, with no store pending, it asserts a sticky `isHalt` together with a stable `ret_val` for the counter to report. It also keeps a saturating retired-instruction count for performance reporting.

## Interface
- `RET_REG`, 3: architectural register whose value is reported as `ret_val`; 0 means the reported value is always 0.
- `DRAIN_CYCLES`, 4: non-pending cycles required after the halt retires before `isHalt` asserts; legal range 1–15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wb_valid`  in  1  an instruction retires this cycle.
- `wb_is_halt`  in  1  the retiring instruction is a halt; qualified by `wb_valid`.
- `wb_we`  in  1  the retiring instruction writes a register; qualified by `wb_valid`.
- `wb_rd`  in  3  destination register of the retiring instruction.
- `wb_data`  in  16  writeback data.
- `store_pending`  in  1  the memory stage has an uncommitted store.
- `isHalt`  out  1  registered; sticky once set.
- `ret_val`  out  16  registered shadow of register `RET_REG`.
- `retired`  out  32  registered retired-instruction count, saturating.

## Operation
- States: RUN, DRAIN, HALTED. Reset enters RUN.
- Reset values: state RUN, `isHalt`=0, `ret_val`=0, `retired`=0, drain counter 0.
- **RUN:**
  - `wb_valid & wb_we & wb_rd==RET_REG & RET_REG!=0` → `ret_val` ← `wb_data`.
  - Writes to r0 are ignored.
  - Any `wb_valid` increments `retired`, which holds at 0xFFFFFFFF.
  - `wb_valid & wb_is_halt` → go to DRAIN, clear the drain counter, count the halt as retired. `wb_we` on the halt retire is ignored, so there is no shadow update.
- **DRAIN:**
  - Further retires are ignored: no shadow update, no count.
  - Each edge with `store_pending`=0: if drain counter == `DRAIN_CYCLES`-1 → go to HALTED and set `isHalt`=1; otherwise increment the counter.
  - `store_pending`=1 holds the counter. There is no timeout.
- **HALTED:**
  - All inputs are ignored.
  - `isHalt`, `ret_val` and `retired` stay frozen until reset.
- A halt with `wb_valid`=0 is not a retire and has no effect.
- `rst_n`=0 in any state, including mid-DRAIN, forces all reset values on that edge. Reset wins over a simultaneous retire.
- The drain counter is 4 bits wide.

## Timing
- Shadow update: `ret_val` reflects the write one edge after the retire cycle.
- A halt retire sampled at edge E0 with `store_pending` low throughout gives `isHalt` high after edge E0+`DRAIN_CYCLES`. With the default this is 4 cycles later.
- Each cycle with `store_pending` high during DRAIN delays `isHalt` by exactly one cycle.
- `isHalt` and `ret_val` are registered, so there is no combinational path from inputs to outputs.
- `ret_val` is stable from the DRAIN entry edge onward. The consumer may sample it in the same cycle `isHalt` is first seen high.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `wb_valid`=1 → all outputs stay 0; after release, `retired` increments from 0.
- **Shadow then halt:**
  - Stimulus: retire a write of 0x002A to r3, then a write of 0x1111 to r2, then a halt; `store_pending`=0.
  - Required: `isHalt` rises exactly 4 cycles after the halt edge, `ret_val`=0x002A, `retired`=3.
- **Store drain:** halt retires with `store_pending` high for 5 cycles starting the next cycle → `isHalt` rises 9 cycles after the halt edge.
- **Post-halt ignore:**
  - Stimulus: a write of 0xBEEF to r3 with `wb_valid` during DRAIN, and another during HALTED.
  - Required: `ret_val` is unchanged, `retired` is unchanged, `isHalt` stays 1.
- **Edge cases:**
  - With `RET_REG`=0, writes to r0 leave `ret_val`=0.
  - A halt carrying `wb_we`=1, `wb_rd`=3, `wb_data`=0xFFFF does not update `ret_val`.
  - `wb_is_halt`=1 with `wb_valid`=0 does nothing.
- **Reset mid-DRAIN and saturation:**
  - Pulse `rst_n` low 2 cycles after a halt → state returns to RUN with all outputs 0, and a later halt works normally.
  - Force `retired` to 0xFFFFFFFE, then retire 3 instructions → `retired` holds at 0xFFFFFFFF.
